// File: rtl/bounce_emulator.sv
// bounce_emulator: turns a clean level request into an LFSR-driven bouncing line.
// Latency: button moves toward the new level on the first edge that sees the change; settles BOUNCE_CYCLES edges later.
// Backpressure: none; level_in changes during a window are ignored until the window has settled.
// Optional feature: define BOUNCE_EMU_EDGE_COUNT_EN to add the 8-bit edge_count output.

module bounce_emulator #(
    parameter int          BOUNCE_CYCLES = 16,
    parameter int          HOLD_BITS     = 2,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level_in,
    output logic       button,
    output logic       busy,
    output logic       settled
`ifdef BOUNCE_EMU_EDGE_COUNT_EN
    ,
    output logic [7:0] edge_count
`endif
);

    localparam int WIN_W  = $clog2(BOUNCE_CYCLES);
    localparam int HOLD_W = HOLD_BITS + 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_BOUNCE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_stable;
    logic                r_target;
    logic                r_button;
    logic                r_settled;
    logic [WIN_W-1:0]    r_win_cnt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [15:0]         r_lfsr;

    logic                w_stable_nxt;
    logic                w_target_nxt;
    logic                w_button_nxt;
    logic                w_settled_nxt;
    logic [WIN_W-1:0]    w_win_nxt;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic [HOLD_W-1:0]   w_hold_reload;
    logic                w_feedback;
    logic [15:0]         w_lfsr_nxt;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1; free-running so the pattern
    // depends on how long after reset a window starts.
    assign w_feedback    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_lfsr_nxt    = {r_lfsr[14:0], w_feedback};

    // Segment length 1..2^HOLD_BITS, drawn from the current (pre-shift) LFSR value.
    assign w_hold_reload = {1'b0, r_lfsr[HOLD_BITS-1:0]} + HOLD_W'(1);

    // LFSR shifts every clock, in both states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= w_lfsr_nxt;
        end
    end

    // Next-state and datapath decisions for the window FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_stable_nxt  = r_stable;
        w_target_nxt  = r_target;
        w_button_nxt  = r_button;
        w_win_nxt     = r_win_cnt;
        w_hold_nxt    = r_hold_cnt;
        w_settled_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (level_in != r_stable) begin
                    // First bounce edge always heads toward the requested level.
                    w_target_nxt = level_in;
                    w_button_nxt = level_in;
                    w_win_nxt    = WIN_W'(BOUNCE_CYCLES - 1);
                    w_hold_nxt   = w_hold_reload;
                    w_state_nxt  = S_BOUNCE;
                end
            end
            S_BOUNCE: begin
                if (r_win_cnt == '0) begin
                    // Window over: force the final level regardless of bounce phase.
                    w_button_nxt  = r_target;
                    w_stable_nxt  = r_target;
                    w_settled_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_win_nxt = r_win_cnt - WIN_W'(1);
                    if (r_hold_cnt == HOLD_W'(1)) begin
                        w_button_nxt = ~r_button;
                        w_hold_nxt   = w_hold_reload;
                    end else begin
                        w_hold_nxt = r_hold_cnt - HOLD_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and window registers; reset aborts any window without a settled pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_stable   <= 1'b0;
            r_target   <= 1'b0;
            r_button   <= 1'b0;
            r_settled  <= 1'b0;
            r_win_cnt  <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_stable   <= w_stable_nxt;
            r_target   <= w_target_nxt;
            r_button   <= w_button_nxt;
            r_settled  <= w_settled_nxt;
            r_win_cnt  <= w_win_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    assign button  = r_button;
    assign busy    = (r_state == S_BOUNCE);
    assign settled = r_settled;

`ifdef BOUNCE_EMU_EDGE_COUNT_EN
    logic       w_window_start;
    logic       w_button_chg;
    logic [7:0] r_edge_cnt;
    logic [7:0] w_edge_cnt_nxt;

    assign w_window_start = (r_state == S_IDLE) && (w_state_nxt == S_BOUNCE);
    assign w_button_chg   = (w_button_nxt != r_button);

    // Count starts at 1 for the entry edge, then counts each change, saturating.
    always_comb begin
        w_edge_cnt_nxt = r_edge_cnt;
        if (w_window_start) begin
            w_edge_cnt_nxt = 8'd1;
        end else if ((r_state == S_BOUNCE) && w_button_chg && (r_edge_cnt != 8'hFF)) begin
            w_edge_cnt_nxt = r_edge_cnt + 8'd1;
        end
    end

    // Edge counter register; holds its last window's value while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge_cnt <= 8'd0;
        end else begin
            r_edge_cnt <= w_edge_cnt_nxt;
        end
    end

    assign edge_count = r_edge_cnt;
`endif

endmodule

// File: tb/tb_bounce_emulator.sv
// Directed bench for bounce_emulator with BOUNCE_CYCLES=16, HOLD_BITS=2, SEED=16'hACE1.
// Outputs are sampled 1 ns after the rising edge; inputs are driven at the same point.
// A free-running reference LFSR predicts each window's button waveform.

module tb_bounce_emulator;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst;
    logic       level_in;
    logic       button;
    logic       busy;
    logic       settled;
`ifdef BOUNCE_EMU_EDGE_COUNT_EN
    logic [7:0] edge_count;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [15:0] m_lfsr;
    logic [16:0] tr_a;
    logic [16:0] tr_b;
    logic [16:0] tr_x;
    logic [16:0] hand;

    always #5 clk = ~clk;

    bounce_emulator #(
        .BOUNCE_CYCLES (16),
        .HOLD_BITS     (2),
        .SEED          (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .level_in   (level_in),
        .button     (button),
        .busy       (busy),
        .settled    (settled)
`ifdef BOUNCE_EMU_EDGE_COUNT_EN
        ,
        .edge_count (edge_count)
`endif
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Reference LFSR, advancing on the same edges as the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= lfsr_step(m_lfsr);
    end

    // Expected button after edges E0..E16 given the LFSR value seen at E0.
    function automatic logic [16:0] exp_wave(input logic [15:0] l0, input logic tgt);
        logic [16:0] w;
        logic [15:0] l;
        logic        b;
        int          h;
        l    = l0;
        b    = tgt;
        h    = 1 + int'(l[1:0]);
        w    = '0;
        w[0] = tgt;
        for (int t = 1; t <= 15; t++) begin
            l = lfsr_step(l);
            if (h == 1) begin
                b = ~b;
                h = 1 + int'(l[1:0]);
            end else begin
                h = h - 1;
            end
            w[t] = b;
        end
        w[16] = tgt;
        return w;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Requests tgt, then checks E0..E16 against the reference; optionally
    // moves level_in to chg_val after edge E<chg_at>.
    task automatic do_window(input logic tgt, input int chg_at, input logic chg_val,
                             output logic [16:0] trace);
        logic [16:0] wave;
        logic        prev;
        int          toggles;
        int          run;
        int          maxrun;
        level_in = tgt;
        wave     = exp_wave(m_lfsr, tgt);
        prev     = button;
        toggles  = 0;
        run      = 0;
        maxrun   = 0;
        trace    = '0;
        for (int t = 0; t <= 16; t++) begin
            step();
            trace[t] = button;
            if (button !== prev) toggles++;
            if (t <= 15) begin
                if (t == 0 || button !== prev) run = 1;
                else                           run = run + 1;
                if (run > maxrun) maxrun = run;
            end
            prev = button;
            chk1("win_button", button, wave[t]);
            chk1("win_busy", busy, t < 16);
            chk1("win_settled", settled, t == 16);
            if (t == chg_at) level_in = chg_val;
        end
        chk1("seg_len_max4", maxrun <= 4, 1'b1);
        chk1("toggle_count_odd", toggles[0], 1'b1);
`ifdef BOUNCE_EMU_EDGE_COUNT_EN
        chkv("edge_count", 32'(edge_count), 32'(toggles));
        chk1("edge_count_odd", edge_count[0], 1'b1);
`endif
    endtask

    initial begin
        rst      = 1'b0;
        level_in = 1'b0;
        #2;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        chk1("rst_button", button, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_settled", settled, 1'b0);
`ifdef BOUNCE_EMU_EDGE_COUNT_EN
        chkv("rst_edge_count", 32'(edge_count), 32'd0);
`endif
        rst = 1'b0;

        // LFSR sequence from SEED, hand-computed.
        step();
        chkv("lfsr_1", 32'(dut.r_lfsr), 32'h59C3);
        step();
        chkv("lfsr_2", 32'(dut.r_lfsr), 32'hB387);
        step();
        chkv("lfsr_3", 32'(dut.r_lfsr), 32'h670F);

        // Idle with no request: outputs stay quiet for the rest of 50 cycles.
        for (int i = 0; i < 47; i++) begin
            step();
            chk1("idle_button", button, 1'b0);
            chk1("idle_busy", busy, 1'b0);
            chk1("idle_settled", settled, 1'b0);
        end

        // Single 0->1 window, then settled drops after one cycle.
        do_window(1'b1, -1, 1'b0, tr_x);
        step();
        chk1("post_settled", settled, 1'b0);
        chk1("post_busy", busy, 1'b0);
        chk1("post_button", button, 1'b1);

        // Back to 0, then a 0->1 window whose request reverts at window cycle 4;
        // that window still settles at 1 and a 1->0 window starts at E17.
        do_window(1'b0, -1, 1'b0, tr_x);
        do_window(1'b1, 4, 1'b0, tr_x);
        chk1("revert_final_button", button, 1'b1);
        do_window(1'b0, -1, 1'b0, tr_x);
        step();
        chk1("revert2_settled", settled, 1'b0);
        chk1("revert2_busy", busy, 1'b0);
        chk1("revert2_button", button, 1'b0);

        // Asynchronous reset at window cycle 5.
        level_in = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk1("pre_abort_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("abort_button", button, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_settled", settled, 1'b0);
`ifdef BOUNCE_EMU_EDGE_COUNT_EN
        chkv("abort_edge_count", 32'(edge_count), 32'd0);
`endif
        step();
        step();
        chk1("abort_hold_settled", settled, 1'b0);
        chk1("abort_hold_busy", busy, 1'b0);

        // Release with level_in=1: window at the first edge, LFSR at SEED.
        rst = 1'b0;
        do_window(1'b1, -1, 1'b0, tr_a);
        hand = 17'h132C3;
        chkv("seed_wave_hand", 32'(tr_a), 32'(hand));
`ifdef BOUNCE_EMU_EDGE_COUNT_EN
        chkv("seed_edge_count_hand", 32'(edge_count), 32'd9);
`endif

        // Same reset timing and stimulus again: identical trace.
        level_in = 1'b0;
        rst = 1'b1;
        step();
        step();
        chk1("rerun_rst_button", button, 1'b0);
        rst = 1'b0;
        do_window(1'b1, -1, 1'b0, tr_b);
        chkv("rerun_identical", 32'(tr_b), 32'(tr_a));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bounce_emulator.md
# bounce_emulator

Synthesizable contact-bounce generator: takes a clean level request and drives a pseudo-randomly bouncing `button` line that settles to the requested level after a fixed window. It is the source-side counterpart of the team's `debouncer`. It sits in FPGA self-test builds, with `button` looped into the debouncer's `button` input, so the debouncer is exercised on hardware without a physical switch.

## Interface
- `BOUNCE_CYCLES`, 16: length of the bounce window in clocks; must be ≥ 2.
- `HOLD_BITS`, 2: hold segment length is 1..2^HOLD_BITS clocks; must be 1..8.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `level_in`  in  1  clean requested button level, synchronous to `clk`.
- `button`  out  1  emulated noisy button line; register output.
- `busy`  out  1  high while a bounce window is in progress.
- `settled`  out  1  one-cycle pulse when `button` reaches its final level.

## Operation
- State machine has two states: IDLE and BOUNCE.
- Internal registers:
  - `stable_q`: last settled level.
  - `target_q`: level latched at window entry.
  - `win_cnt`: width clog2(BOUNCE_CYCLES).
  - `hold_cnt`: width HOLD_BITS+1.
  - `lfsr`: 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1. It shifts every clock in both states.
- IDLE:
  - `button` = `stable_q`, `busy` = 0.
  - When `level_in` != `stable_q` at an edge:
    - target_q ← level_in
    - button ← level_in (the first bounce edge goes toward the target)
    - win_cnt ← BOUNCE_CYCLES−1
    - hold_cnt ← 1 + lfsr[HOLD_BITS−1:0]
    - state ← BOUNCE
- BOUNCE, at each edge:
  - If win_cnt == 0: button ← target_q, stable_q ← target_q, settled ← 1, state ← IDLE.
  - Otherwise win_cnt decrements.
    - If hold_cnt == 1: `button` inverts and hold_cnt reloads with 1 + lfsr[HOLD_BITS−1:0].
    - Else hold_cnt decrements.
- `level_in` changes during BOUNCE are ignored. If `level_in` still differs from `stable_q` once IDLE is re-entered, a new window starts on the next edge.
- `settled` is high for exactly one cycle per window and is 0 otherwise.

## Timing
- Reset values, forced asynchronously by `rst`:
  - button = 0, stable_q = 0, busy = 0, settled = 0
  - state = IDLE, lfsr = SEED, counters = 0
- Reset mid-window aborts immediately. No settled pulse is produced.
- Edge E0 is the first edge that sees a mismatch. `button` changes at E0.
- `busy` is high from E0 through E_BOUNCE_CYCLES, i.e. exactly BOUNCE_CYCLES cycles.
- `settled` is high for the cycle after E_BOUNCE_CYCLES, and `busy` is 0 during that cycle.
- The earliest next window entry is edge E_BOUNCE_CYCLES+1.
- Segment length between internal toggles is 1..2^HOLD_BITS cycles. The final segment may be truncated by the window end.
- The output is deterministic: identical SEED, reset release time and stimulus give an identical `button` waveform.

## Configuration
- `BOUNCE_EMU_EDGE_COUNT_EN` defined:
  - Adds output `edge_count`, 8 bits: number of `button` value changes in the current or last window, including E0 and the final forced change.
  - Set to 1 at E0, increments on each change, saturates at 255.
  - Holds its value in IDLE; reset value 0.
  - The count is always odd for an unsaturated window.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Test plan
Defaults used: BOUNCE_CYCLES=16, HOLD_BITS=2, SEED=16'hACE1.
1. Reset asserted for 3 cycles with `level_in`=0 → button=0, busy=0, settled=0; these hold for 50 idle cycles with no activity.
2. `level_in` 0→1 → button=1 at E0; busy high exactly 16 cycles; every bounce segment lasts 1–4 cycles; final button=1; settled pulses once for 1 cycle. With the macro, edge_count is odd and matches the number of observed toggles.
3. `level_in` 0→1, then back to 0 at window cycle 4 → window completes with button=1 and a settled pulse. A second window starts at E17 and settles button=0 at E33.
4. `rst` asserted asynchronously (mid-cycle) at window cycle 5 → button=0 and busy=0 before the next edge. After release with `level_in`=1, a new window starts on the first edge.
5. Two runs with the same SEED and same stimulus → bit-identical `button` traces that match a behavioural LFSR reference model cycle-for-cycle.
6. `button` looped into `debouncer` with 1000-cycle `level_in` steps → debouncer `button_state` shows exactly one clean transition per step, with no glitch.
